switch_nport: RTL and testbench
===============================

# switch_nport

Parametrised N-port address-routed switch with per-port buffering and valid/ready flow control. It is the successor to the two-port address-split switch: it generalises to NUM_PORTS outputs, routes by address MSBs, queues traffic per port in FIFO_DEPTH-entry FIFOs, and applies backpressure instead of overwriting. It sits between a single ingress stream and NUM_PORTS independent downstream consumers.

## Interface
- ADDR_WIDTH, 8, address width in bits
- DATA_WIDTH, 16, data width in bits
- NUM_PORTS, 4, output port count; power of two, 2..2^ADDR_WIDTH
- FIFO_DEPTH, 4, entries per port FIFO; power of two, >= 2
- clk  input  1  clock, all logic on rising edge
- rstn  input  1  reset, asynchronous, active-low
- vld  input  1  ingress word valid
- rdy  output  1  ingress ready; transfer when vld && rdy at rising edge
- addr  input  ADDR_WIDTH  ingress address
- data  input  DATA_WIDTH  ingress data
- out_vld  output  NUM_PORTS  per-port egress valid
- out_rdy  input  NUM_PORTS  per-port egress ready
- out_addr  output  NUM_PORTS*ADDR_WIDTH  port p at bits [p*ADDR_WIDTH +: ADDR_WIDTH]
- out_data  output  NUM_PORTS*DATA_WIDTH  port p at bits [p*DATA_WIDTH +: DATA_WIDTH]
- out_cnt  output  NUM_PORTS*$clog2(FIFO_DEPTH+1)  per-port FIFO occupancy

## Operation
- Destination port dest = addr[ADDR_WIDTH-1 -: $clog2(NUM_PORTS)] (address space split into NUM_PORTS equal ranges; port 0 = lowest range).
- rdy = !full[dest]; combinational from addr and FIFO state; independent of vld.
- On vld && rdy: {addr, data} pushed into FIFO[dest]; no other FIFO changes. Address stored unmodified.
- vld with rdy low: no push, no drop; source must hold addr/data/vld until accepted.
- Each port FIFO: write pointer, read pointer ($clog2(FIFO_DEPTH) bits, wrap naturally at FIFO_DEPTH), occupancy counter 0..FIFO_DEPTH. full = (cnt == FIFO_DEPTH), empty = (cnt == 0).
- Egress first-word-fall-through: out_vld[p] = !empty[p]; out_addr/out_data[p] = head entry when out_vld[p], else forced to 0.
- Pop on out_vld[p] && out_rdy[p]; read pointer advances, cnt decrements.
- Push and pop on same port same cycle: cnt unchanged, both pointers advance. Allowed only when not full (rdy is from full alone, so push into a full FIFO is refused even if a pop occurs that cycle).
- Ports are fully independent: stall on one port never blocks egress on others; ingress blocks only while the current head-of-line word targets a full port.
- Ordering: per-port FIFO order; no ordering guarantee across ports.

## Timing
- Reset (rstn low, asynchronous): all pointers and counters 0; out_vld = 0, out_addr = 0, out_data = 0, out_cnt = 0; rdy = 1 while rstn low. Storage array contents not reset (masked by out_vld).
- Reset release: first transfer accepted on first rising edge with rstn high.
- Reset asserted mid-operation: all queued words discarded immediately; outputs return to reset values without waiting for clk.
- Latency: word accepted at edge k into an empty FIFO appears on out_vld/out_addr/out_data after edge k (one cycle).
- Throughput: one ingress word per cycle; one egress word per port per cycle.
- rdy falls combinationally after the edge that makes FIFO[dest] full; rises after the edge that pops from it.

## Test plan
- Routing: reset, out_rdy = 4'b1111; send addr 8'h10/8'h50/8'h90/8'hD0 with data 16'hA000..A003 -> each appears once, one cycle later, on ports 0/1/2/3 respectively; other ports' out_vld stay 0.
- Full/backpressure: out_rdy[1] = 0; send 5 words to addr 8'h40 -> first 4 accepted, out_cnt[1] = 4, rdy = 0 on 5th; raise out_rdy[1] -> 5th accepted after first pop; port 1 emits all 5 in order.
- Simultaneous push/pop: port 2 at cnt 2, out_rdy[2] = 1, push to 8'h80 each cycle for 10 cycles -> cnt stays 2, no loss, in-order output, pointers wrap correctly.
- Port isolation: port 0 full and stalled, stream to port 3 with out_rdy[3] = 1 -> port 3 traffic flows uninterrupted; rdy = 0 only when addr targets port 0.
- Reset mid-operation: fill ports 0 and 2 with 3 words each, drop rstn between edges -> out_vld = 0, out_cnt = 0, out_addr/out_data = 0 immediately; after release, empty FIFOs, first new word routed normally.
- Parameter sweep: NUM_PORTS = 2, FIFO_DEPTH = 8, ADDR_WIDTH = 6 -> addr 6'h1F to port 0, 6'h20 to port 1; full asserted at 8 entries.

Source files
------------

// File: rtl/switch_nport.sv
// N-port address-routed switch: one ingress stream fans out by address MSBs
// into per-port FIFOs with first-word-fall-through egress and backpressure.
module switch_nport #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_PORTS  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                          clk,
  input  logic                                          rstn,
  input  logic                                          vld,
  output logic                                          rdy,
  input  logic [ADDR_WIDTH-1:0]                         addr,
  input  logic [DATA_WIDTH-1:0]                         data,
  output logic [NUM_PORTS-1:0]                          out_vld,
  input  logic [NUM_PORTS-1:0]                          out_rdy,
  output logic [NUM_PORTS*ADDR_WIDTH-1:0]               out_addr,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]               out_data,
  output logic [NUM_PORTS*$clog2(FIFO_DEPTH+1)-1:0]     out_cnt
);

  localparam int PW   = $clog2(NUM_PORTS);
  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(FIFO_DEPTH+1);
  localparam int EW   = ADDR_WIDTH + DATA_WIDTH;

  // Handshake: a word moves when valid and ready are both high at a rising
  // edge; ready never depends on valid, and a stalled source holds its word.
  logic [PW-1:0]        dest;
  logic [NUM_PORTS-1:0] full;

  assign dest = addr[ADDR_WIDTH-1 -: PW];
  assign rdy  = !full[dest];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [EW-1:0]   mem_q [FIFO_DEPTH];
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            push, pop, empty;
    logic [EW-1:0]   head;

    assign full[p] = (cnt_q == CW'(FIFO_DEPTH));
    assign empty   = (cnt_q == '0);
    assign push    = vld && rdy && (dest == PW'(p));
    assign pop     = !empty && out_rdy[p];

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) wr_ptr_d = wr_ptr_q + PTRW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTRW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
      end
    end

    // Storage is left unreset; an empty FIFO masks it on the outputs.
    always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {addr, data};
    end

    assign head                               = mem_q[rd_ptr_q];
    assign out_vld[p]                         = !empty;
    assign out_addr[p*ADDR_WIDTH +: ADDR_WIDTH] = empty ? '0 : head[EW-1 -: ADDR_WIDTH];
    assign out_data[p*DATA_WIDTH +: DATA_WIDTH] = empty ? '0 : head[DATA_WIDTH-1:0];
    assign out_cnt[p*CW +: CW]                = cnt_q;
  end

endmodule

// File: tb/tb_switch_nport.sv
// Bench for switch_nport: default instance checked against per-port queues,
// plus a second instance with 2 ports, depth 8 and 6-bit addresses.
module tb_switch_nport;
  localparam int AW = 8, DW = 16, NP = 4, FD = 4, CW = 3, EW = AW + DW;
  localparam int AW2 = 6, NP2 = 2, FD2 = 8, CW2 = 4;

  logic              clk, rstn;
  logic              vld, rdy;
  logic [AW-1:0]     addr;
  logic [DW-1:0]     data;
  logic [NP-1:0]     out_vld, out_rdy;
  logic [NP*AW-1:0]  out_addr;
  logic [NP*DW-1:0]  out_data;
  logic [NP*CW-1:0]  out_cnt;

  logic              vld2, rdy2;
  logic [AW2-1:0]    addr2;
  logic [DW-1:0]     data2;
  logic [NP2-1:0]    out_vld2, out_rdy2;
  logic [NP2*AW2-1:0] out_addr2;
  logic [NP2*DW-1:0] out_data2;
  logic [NP2*CW2-1:0] out_cnt2;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected per-port contents, oldest word first.
  logic [EW-1:0] exp_q [NP][$];

  switch_nport #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(NP), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rstn(rstn), .vld(vld), .rdy(rdy), .addr(addr), .data(data),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_addr(out_addr), .out_data(out_data),
    .out_cnt(out_cnt));

  switch_nport #(.ADDR_WIDTH(AW2), .DATA_WIDTH(DW), .NUM_PORTS(NP2), .FIFO_DEPTH(FD2)) dut2 (
    .clk(clk), .rstn(rstn), .vld(vld2), .rdy(rdy2), .addr(addr2), .data(data2),
    .out_vld(out_vld2), .out_rdy(out_rdy2), .out_addr(out_addr2), .out_data(out_data2),
    .out_cnt(out_cnt2));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: address space split into NP equal ranges
  function automatic int dest_of(logic [AW-1:0] a);
    return int'(a) / ((1 << AW) / NP);
  endfunction

  function automatic bit exp_rdy(logic [AW-1:0] a);
    return exp_q[dest_of(a)].size() < FD;
  endfunction

  function automatic logic [NP-1:0] exp_vld();
    logic [NP-1:0] v;
    v = '0;
    for (int p = 0; p < NP; p++) v[p] = (exp_q[p].size() > 0);
    return v;
  endfunction

  function automatic logic [NP*AW-1:0] exp_addr_bus();
    logic [NP*AW-1:0] b;
    logic [EW-1:0]    e;
    b = '0;
    for (int p = 0; p < NP; p++)
      if (exp_q[p].size() > 0) begin
        e = exp_q[p][0];
        b[p*AW +: AW] = e[EW-1 -: AW];
      end
    return b;
  endfunction

  function automatic logic [NP*DW-1:0] exp_data_bus();
    logic [NP*DW-1:0] b;
    logic [EW-1:0]    e;
    b = '0;
    for (int p = 0; p < NP; p++)
      if (exp_q[p].size() > 0) begin
        e = exp_q[p][0];
        b[p*DW +: DW] = e[DW-1:0];
      end
    return b;
  endfunction

  function automatic logic [NP*CW-1:0] exp_cnt_bus();
    logic [NP*CW-1:0] b;
    for (int p = 0; p < NP; p++) b[p*CW +: CW] = CW'(exp_q[p].size());
    return b;
  endfunction

  // driver: one clock cycle from a negedge to the next, model follows the edge
  task automatic cycle();
    bit            do_push;
    logic [EW-1:0] w;
    int            d;
    bit [NP-1:0]   do_pop;
    do_push = vld && exp_rdy(addr);
    w       = {addr, data};
    d       = dest_of(addr);
    for (int p = 0; p < NP; p++) do_pop[p] = (exp_q[p].size() > 0) && out_rdy[p];
    @(posedge clk);
    for (int p = 0; p < NP; p++) if (do_pop[p]) void'(exp_q[p].pop_front());
    if (do_push) exp_q[d].push_back(w);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0; vld = 1'b0; addr = '0; data = '0; out_rdy = '0;
    vld2 = 1'b0; addr2 = '0; data2 = '0; out_rdy2 = '0;
    #1;
    n_checks++; if (rdy !== 1'b1) $display("FAIL reset_rdy: got %b want 1", rdy); else n_pass++;
    n_checks++; if (out_vld !== '0) $display("FAIL reset_vld: got %b want 0", out_vld); else n_pass++;
    n_checks++; if (out_addr !== '0 || out_data !== '0)
      $display("FAIL reset_bus: got addr %h data %h want 0", out_addr, out_data); else n_pass++;
    n_checks++; if (out_cnt !== '0) $display("FAIL reset_cnt: got %h want 0", out_cnt); else n_pass++;
    n_checks++; if (out_vld2 !== '0 || rdy2 !== 1'b1)
      $display("FAIL reset_dut2: got vld %b rdy %b want 00/1", out_vld2, rdy2); else n_pass++;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_routing();
    out_rdy = '1;
    for (int i = 0; i < NP; i++) begin
      vld = 1'b1; addr = 8'h10 + AW'(i * 64); data = 16'hA000 + DW'(i);
      #1;
      n_checks++; if (rdy !== 1'b1) $display("FAIL route_rdy %0d: got %b want 1", i, rdy); else n_pass++;
      cycle();
      vld = 1'b0;
      #1;
      n_checks++; if (out_vld !== NP'(1 << i))
        $display("FAIL route_vld %0d: got %b want %b", i, out_vld, NP'(1 << i)); else n_pass++;
      n_checks++; if (out_data[i*DW +: DW] !== 16'hA000 + DW'(i) || out_addr[i*AW +: AW] !== 8'h10 + AW'(i * 64))
        $display("FAIL route_word %0d: got %h/%h want %h/%h", i, out_addr[i*AW +: AW],
                 out_data[i*DW +: DW], 8'h10 + AW'(i * 64), 16'hA000 + DW'(i)); else n_pass++;
      cycle();
    end
    #1;
    n_checks++; if (out_vld !== '0) $display("FAIL route_drain: got %b want 0", out_vld); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] sent[$];
    logic [DW-1:0] got[$];
    out_rdy = 4'b1101;
    for (int k = 0; k < 5; k++) begin
      vld = 1'b1; addr = 8'h40; data = DW'($urandom);
      sent.push_back(data);
      #1;
      n_checks++; if (rdy !== (k < 4)) $display("FAIL bp_rdy word %0d: got %b want %b", k, rdy, k < 4); else n_pass++;
      if (k < 4) cycle();
    end
    n_checks++; if (out_cnt[1*CW +: CW] !== 3'd4)
      $display("FAIL bp_cnt: got %0d want 4", out_cnt[1*CW +: CW]); else n_pass++;
    out_rdy = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      if (i >= 2) vld = 1'b0;
      #1;
      if (i < 2) begin
        n_checks++; if (rdy !== (i == 1))
          $display("FAIL bp_release %0d: got %b want %b", i, rdy, i == 1); else n_pass++;
      end
      if (out_vld[1]) got.push_back(out_data[1*DW +: DW]);
      cycle();
    end
    n_checks++; if (got.size() != 5) $display("FAIL bp_count: got %0d want 5", got.size()); else n_pass++;
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      n_checks++; if (got[i] !== sent[i])
        $display("FAIL bp_order %0d: got %h want %h", i, got[i], sent[i]); else n_pass++;
    end
  endtask

  task automatic test_push_pop();
    logic [DW-1:0] sent[$];
    logic [DW-1:0] got[$];
    out_rdy = 4'b1011;
    for (int i = 0; i < 2; i++) begin
      vld = 1'b1; addr = 8'h80; data = DW'($urandom); sent.push_back(data);
      cycle();
    end
    out_rdy = 4'b1111;
    for (int i = 0; i < 14; i++) begin
      vld = (i < 10); addr = 8'h80; data = DW'($urandom);
      if (vld) sent.push_back(data);
      #1;
      if (i < 10) begin
        n_checks++; if (out_cnt[2*CW +: CW] !== 3'd2 || rdy !== 1'b1)
          $display("FAIL pp_steady %0d: got cnt %0d rdy %b want 2/1", i, out_cnt[2*CW +: CW], rdy); else n_pass++;
      end
      if (out_vld[2]) got.push_back(out_data[2*DW +: DW]);
      cycle();
    end
    n_checks++; if (got.size() != sent.size())
      $display("FAIL pp_count: got %0d want %0d", got.size(), sent.size()); else n_pass++;
    for (int i = 0; i < sent.size() && i < got.size(); i++) begin
      n_checks++; if (got[i] !== sent[i])
        $display("FAIL pp_order %0d: got %h want %h", i, got[i], sent[i]); else n_pass++;
    end
  endtask

  task automatic test_isolation();
    bit to_p0;
    out_rdy = 4'b1000;
    for (int i = 0; i < FD; i++) begin
      vld = 1'b1; addr = AW'($urandom_range(0, 63)); data = DW'($urandom);
      cycle();
    end
    for (int i = 0; i < 30; i++) begin
      to_p0 = ($urandom_range(0, 2) == 0);
      addr  = to_p0 ? AW'($urandom_range(0, 63)) : AW'($urandom_range(192, 255));
      vld   = !to_p0;
      data  = DW'($urandom);
      #1;
      n_checks++; if (rdy !== !to_p0)
        $display("FAIL iso_rdy %0d: addr %h got %b want %b", i, addr, rdy, !to_p0); else n_pass++;
      n_checks++; if (out_vld !== exp_vld() || out_data !== exp_data_bus() || out_cnt[CW-1:0] !== 3'd4)
        $display("FAIL iso_out %0d: got vld %b data %h cnt0 %0d want %b %h 4", i, out_vld, out_data,
                 out_cnt[CW-1:0], exp_vld(), exp_data_bus()); else n_pass++;
      cycle();
    end
    vld = 1'b0; out_rdy = '1;
    for (int i = 0; i < FD + 1; i++) cycle();
  endtask

  task automatic test_random();
    bit held;
    held = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!held) begin
        vld = ($urandom_range(0, 3) != 0); addr = AW'($urandom); data = DW'($urandom);
      end
      out_rdy = NP'($urandom);
      #1;
      n_checks++; if (rdy !== exp_rdy(addr))
        $display("FAIL rand_rdy %0d: got %b want %b", i, rdy, exp_rdy(addr)); else n_pass++;
      n_checks++; if (out_vld !== exp_vld())
        $display("FAIL rand_vld %0d: got %b want %b", i, out_vld, exp_vld()); else n_pass++;
      n_checks++; if (out_addr !== exp_addr_bus() || out_data !== exp_data_bus())
        $display("FAIL rand_word %0d: got %h/%h want %h/%h", i, out_addr, out_data,
                 exp_addr_bus(), exp_data_bus()); else n_pass++;
      n_checks++; if (out_cnt !== exp_cnt_bus())
        $display("FAIL rand_cnt %0d: got %h want %h", i, out_cnt, exp_cnt_bus()); else n_pass++;
      held = vld && !exp_rdy(addr);
      cycle();
    end
    vld = 1'b0; out_rdy = '1;
    for (int i = 0; i < FD + 1; i++) cycle();
  endtask

  task automatic test_reset_mid();
    out_rdy = '0;
    for (int i = 0; i < 6; i++) begin
      vld  = 1'b1;
      addr = (i < 3) ? AW'($urandom_range(0, 63)) : AW'($urandom_range(128, 191));
      data = DW'($urandom);
      cycle();
    end
    vld = 1'b0;
    #1;
    n_checks++; if (out_cnt !== 12'b000_011_000_011)
      $display("FAIL mid_fill: got %b want 000011000011", out_cnt); else n_pass++;
    #1 rstn = 1'b0;
    #1;
    n_checks++; if (out_vld !== '0 || out_cnt !== '0 || out_addr !== '0 || out_data !== '0 || rdy !== 1'b1)
      $display("FAIL mid_reset: got vld %b cnt %h addr %h data %h rdy %b want all 0, rdy 1",
               out_vld, out_cnt, out_addr, out_data, rdy); else n_pass++;
    for (int p = 0; p < NP; p++) exp_q[p].delete();
    @(negedge clk);
    rstn = 1'b1;
    out_rdy = '1; vld = 1'b1; addr = 8'hC5; data = 16'h5A5A;
    #1;
    n_checks++; if (rdy !== 1'b1) $display("FAIL mid_rdy: got %b want 1", rdy); else n_pass++;
    cycle();
    vld = 1'b0;
    #1;
    n_checks++; if (out_vld !== 4'b1000 || out_addr[3*AW +: AW] !== 8'hC5 || out_data[3*DW +: DW] !== 16'h5A5A)
      $display("FAIL mid_first: got %b %h/%h want 1000 c5/5a5a", out_vld, out_addr[3*AW +: AW],
               out_data[3*DW +: DW]); else n_pass++;
    cycle();
  endtask

  task automatic test_sweep();
    vld = 1'b0; out_rdy2 = '0;
    vld2 = 1'b1; addr2 = 6'h1F; data2 = 16'h1111;
    cycle();
    vld2 = 1'b0;
    #1;
    n_checks++; if (out_vld2 !== 2'b01 || out_addr2[AW2-1:0] !== 6'h1F || out_data2[DW-1:0] !== 16'h1111)
      $display("FAIL sweep_p0: got %b %h/%h want 01 1f/1111", out_vld2, out_addr2[AW2-1:0],
               out_data2[DW-1:0]); else n_pass++;
    vld2 = 1'b1; addr2 = 6'h20; data2 = 16'h2222;
    cycle();
    vld2 = 1'b0;
    #1;
    n_checks++; if (out_vld2 !== 2'b11 || out_addr2[AW2 +: AW2] !== 6'h20 || out_data2[DW +: DW] !== 16'h2222)
      $display("FAIL sweep_p1: got %b %h/%h want 11 20/2222", out_vld2, out_addr2[AW2 +: AW2],
               out_data2[DW +: DW]); else n_pass++;
    for (int i = 1; i < FD2; i++) begin
      vld2 = 1'b1; addr2 = AW2'($urandom_range(32, 63)); data2 = DW'($urandom);
      #1;
      n_checks++; if (rdy2 !== 1'b1) $display("FAIL sweep_fill %0d: got %b want 1", i, rdy2); else n_pass++;
      cycle();
    end
    addr2 = 6'h3F;
    #1;
    n_checks++; if (rdy2 !== 1'b0 || out_cnt2[CW2 +: CW2] !== 4'd8 || out_cnt2[CW2-1:0] !== 4'd1)
      $display("FAIL sweep_full: got rdy %b cnt %h want 0, 8/1", rdy2, out_cnt2); else n_pass++;
    addr2 = 6'h05;
    #1;
    n_checks++; if (rdy2 !== 1'b1) $display("FAIL sweep_other: got %b want 1", rdy2); else n_pass++;
    vld2 = 1'b0;
    cycle();
  endtask

  initial begin
    test_reset();
    test_routing();
    test_backpressure();
    test_push_pop();
    test_isolation();
    test_random();
    test_reset_mid();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
